t05_bit_packer: RTL and testbench
=================================

Name: t05_bit_packer

Overview:
- Serial-to-byte packer directly downstream of the header synthesis stage.
- Collects the single-bit stream qualified by enable (header bits, backtrack zeroes, char-path bits) into MSB-first bytes.
- Buffers completed bytes in a small FIFO and presents them on a valid/ready byte interface to the SPI/SRAM writer.
- Upstream has no backpressure, so the FIFO absorbs writer stalls. FIFO overflow is flagged, never silently hidden.

Parameters:
- FIFO_DEPTH, 4, number of byte entries; power of two, 2..16.
- CNT_W, 16, width of the total-bit counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- clear  in  1  synchronous soft clear; same effect as reset, applied on the next edge.
- bit_in  in  1  serial data bit (upstream bit1).
- bit_valid  in  1  bit_in is valid this cycle (upstream enable).
- flush  in  1  one-cycle pulse: end of stream; pad the partial byte and drain.
- byte_out  out  8  FIFO head byte.
- byte_valid  out  1  FIFO non-empty.
- byte_ready  in  1  downstream accepts byte_out when byte_valid && byte_ready.
- flush_done  out  1  one-cycle pulse when a flush has fully drained.
- overflow  out  1  sticky: a completed byte was dropped because the FIFO was full.
- total_bits  out  CNT_W  count of bits accepted since reset/clear; saturates at all-ones.
- busy  out  1  high in DRAIN state or when byte_valid.

Behaviour:
- Reset and clear values: accumulator=0, bit count=0, FIFO empty, state=IDLE, byte_valid=0, byte_out=0, flush_done=0, overflow=0, total_bits=0, busy=0. clear has priority over every other input in the same cycle.
- Accumulator and bit count:
  - 8-bit shift register acc plus a 3-bit count n.
  - On bit_valid: acc<={acc[6:0],bit_in}, n<=n+1 (mod 8), total_bits+1 (saturating).
  - On the 8th bit (n==7 && bit_valid), the byte {acc[6:0],bit_in} is pushed into the FIFO on the same edge and n returns to 0.
  - Latency: byte_valid is high the cycle after the 8th bit's edge if the FIFO was empty.
- Flush:
  - flush with n==0 and no bit_valid: no push.
  - flush with 0<n<8: push {acc[n-1:0], (8-n) zeroes}, i.e. left-justified and zero-padded; n<=0.
  - flush together with bit_valid: the bit is included first.
    - If that bit completes the byte, push only that byte (no extra pad byte).
    - Otherwise pad the result as above.
- FSM (2 bits):
  - IDLE: the accumulator runs. The first bit_valid moves to PACK.
  - PACK: the accumulator runs. flush moves to DRAIN, performing the padding push on the same edge.
  - DRAIN: wait until the FIFO is empty (including the pad byte). flush_done pulses for exactly one cycle on the cycle the FIFO becomes empty, then the FSM goes to IDLE.
  - flush received in IDLE: go to DRAIN anyway. flush_done pulses once the FIFO is empty, which is the next cycle if already empty.
  - bit_valid during DRAIN: bits are still accepted into a new byte. Their completion does not delay flush_done beyond the FIFO-empty condition at entry accounting. Rule: flush_done fires when the FIFO is empty, regardless of the partial acc.
  - flush during DRAIN: ignored.
- FIFO:
  - Circular buffer with rd/wr pointers plus a count.
  - Pop when byte_valid && byte_ready.
  - Simultaneous push and pop when full: both happen, no overflow.
  - Push when full without a pop: byte dropped, overflow<=1 (sticky until reset/clear), FIFO contents unchanged.
  - Pop when empty: impossible (byte_valid=0), no pointer change.
  - Pointers wrap modulo FIFO_DEPTH.
- byte_out is registered FIFO head data. It holds a stable value while byte_valid && !byte_ready.
- Reset mid-operation: all state is discarded immediately (asynchronous). The partial byte is lost and no flush_done is generated.

Decomposition:
- Shared package t05_pkg: packer state enum (PK_IDLE, PK_PACK, PK_DRAIN) and the constant BYTE_W=8.
- One sub-module: t05_byte_fifo (parameterised FIFO_DEPTH, 8-bit, push/pop/full/empty/count). The packer instantiates it.
- Accumulator and FSM stay in t05_bit_packer.

Test Plan:
- Bits 1,0,1,1,0,0,1,0 on consecutive cycles, byte_ready=1 -> byte_out=0xB2 with byte_valid the cycle after the 8th bit; total_bits=8.
- 9-bit header {1,0x41} (1,0,1,0,0,0,0,0,1), then flush -> bytes 0xA0, then 0x80 (pad); flush_done pulses once after the second pop; total_bits=9.
- 8th bit and flush in the same cycle (bits 0xFF) -> exactly one byte 0xFF, no pad byte; flush_done follows.
- byte_ready=0, stream 5 full bytes with FIFO_DEPTH=4 -> first 4 bytes retained in order; 5th dropped; overflow=1. Then byte_ready=1 -> 4 bytes out; overflow stays 1.
- FIFO full, and a 9th-bit push coincides with byte_ready=1 -> no overflow; count stays 4; order preserved.
- rst driven low mid-byte (3 bits in) -> all outputs at reset values immediately; after release, a new 8-bit stream packs from bit 0. Also check clear=1 with bit_valid=1 -> bit discarded.

Source files
------------

// File: rtl/t05_pkg.sv
// Shared types and constants for the bit packer and its byte FIFO.
package t05_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    PK_IDLE  = 2'd0,
    PK_PACK  = 2'd1,
    PK_DRAIN = 2'd2
  } pk_state_e;

endpackage

// File: rtl/t05_byte_fifo.sv
// Small circular byte FIFO with a registered head byte so the output never glitches.
module t05_byte_fifo
  import t05_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          push,
  input  logic [BYTE_W-1:0]             push_data,
  input  logic                          pop,
  output logic [BYTE_W-1:0]             head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  logic [BYTE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_inc;
  logic [AW:0]       count_q, count_d;
  logic [BYTE_W-1:0] head_q, head_d;
  logic              do_push, do_pop;

  always_comb begin
    do_pop     = pop && (count_q != '0);
    do_push    = push && ((count_q != DEPTH_C) || do_pop);
    rd_ptr_inc = rd_ptr_q + AW'(1);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    head_d     = head_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_inc;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    // Head must already hold the next byte when the pop edge completes.
    if (do_pop) begin
      if (count_q > (AW + 1)'(1)) head_d = mem[rd_ptr_inc];
      else if (do_push)           head_d = push_data;
      else                        head_d = '0;
    end else if ((count_q == '0) && do_push) begin
      head_d = push_data;
    end
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      head_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr_q] <= push_data;
  end

  assign head  = head_q;
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

endmodule

// File: rtl/t05_bit_packer.sv
// Packs a qualified serial bit stream into MSB-first bytes, pads on flush,
// and buffers bytes for a valid/ready consumer.
module t05_bit_packer
  import t05_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              flush,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              flush_done,
  output logic              overflow,
  output logic [CNT_W-1:0]  total_bits,
  output logic              busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  pk_state_e         state_q, state_d;
  logic [BYTE_W-1:0] acc_q, acc_d, acc_in;
  logic [2:0]        n_q, n_d;
  logic [3:0]        n_in;
  logic [CNT_W-1:0]  total_q, total_d;
  logic              flush_done_q, flush_done_d;
  logic              overflow_q, overflow_d;
  logic              push, pop, flush_acc, empty_next;
  logic [BYTE_W-1:0] push_data;
  logic              fifo_full, fifo_empty;
  logic [AW:0]       fifo_count;

  always_comb begin
    acc_in       = bit_valid ? {acc_q[BYTE_W-2:0], bit_in} : acc_q;
    n_in         = {1'b0, n_q} + {3'b000, bit_valid};
    flush_acc    = flush && (state_q != PK_DRAIN);
    pop          = byte_valid && byte_ready;
    acc_d        = acc_in;
    n_d          = n_in[2:0];
    total_d      = total_q;
    push         = 1'b0;
    push_data    = '0;
    state_d      = state_q;
    flush_done_d = 1'b0;
    overflow_d   = overflow_q;

    if (bit_valid && (total_q != '1)) total_d = total_q + CNT_W'(1);

    // A completing bit takes precedence, so a coincident flush adds no pad byte.
    if (bit_valid && (n_q == 3'd7)) begin
      push      = 1'b1;
      push_data = acc_in;
      n_d       = 3'd0;
    end else if (flush_acc && (n_in != 4'd0)) begin
      push      = 1'b1;
      push_data = acc_in << (4'd8 - n_in);
      n_d       = 3'd0;
      acc_d     = '0;
    end

    if (push && fifo_full && !pop) overflow_d = 1'b1;
    empty_next = !push && (fifo_empty || ((fifo_count == (AW + 1)'(1)) && pop));

    case (state_q)
      PK_IDLE: begin
        if (flush)          state_d = PK_DRAIN;
        else if (bit_valid) state_d = PK_PACK;
      end
      PK_PACK: begin
        if (flush) state_d = PK_DRAIN;
      end
      PK_DRAIN: state_d = PK_DRAIN;
      default:  state_d = PK_IDLE;
    endcase

    // Drain completes on the edge that leaves the FIFO empty.
    if ((state_d == PK_DRAIN) && empty_next) begin
      flush_done_d = 1'b1;
      state_d      = PK_IDLE;
    end

    if (clear) begin
      acc_d        = '0;
      n_d          = '0;
      total_d      = '0;
      push         = 1'b0;
      state_d      = PK_IDLE;
      flush_done_d = 1'b0;
      overflow_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= PK_IDLE;
      acc_q        <= '0;
      n_q          <= '0;
      total_q      <= '0;
      flush_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      n_q          <= n_d;
      total_q      <= total_d;
      flush_done_q <= flush_done_d;
      overflow_q   <= overflow_d;
    end
  end

  t05_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (byte_out),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign byte_valid = !fifo_empty;
  assign flush_done = flush_done_q;
  assign overflow   = overflow_q;
  assign total_bits = total_q;
  assign busy       = (state_q == PK_DRAIN) || byte_valid;

endmodule

// File: tb/tb_t05_bit_packer.sv
// Directed bench: stimulus queues expected bytes, a negedge monitor pops and compares.
module tb_t05_bit_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        flush = 1'b0;
  logic        byte_ready = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        flush_done;
  logic        overflow;
  logic [15:0] total_bits;
  logic        busy;

  int total = 0;
  int bad = 0;
  int fd_cnt = 0;
  int pop_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  t05_bit_packer #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .clear     (clear),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .flush     (flush),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .flush_done(flush_done),
    .overflow  (overflow),
    .total_bits(total_bits),
    .busy      (busy)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endfunction

  // Monitor: every accepted byte is checked against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && !clear) begin
      if (flush_done) fd_cnt++;
      if (byte_valid && byte_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {24'd0, byte_out}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("byte_out", {24'd0, byte_out}, {24'd0, e});
        end
      end
    end
  end

  task automatic send_bits(input logic [7:0] v, input int nb, input bit flush_last);
    for (int i = 0; i < nb; i++) begin
      bit_in    = v[7-i];
      bit_valid = 1'b1;
      flush     = flush_last && (i == nb - 1);
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_clear();
    byte_ready = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_q.delete();
    fd_cnt  = 0;
    pop_cnt = 0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (!busy && exp_q.size() == 0) break;
    end
    if (k == 60) chk({name, "_drain_timeout"}, 32'd1, 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    chk("rst_total_bits", {16'd0, total_bits}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: one byte, latency and bit count
    byte_ready = 1'b1;
    exp_q.push_back(8'hB2);
    send_bits(8'hB2, 8, 1'b0);
    chk("t1_latency_valid", {31'd0, byte_valid}, 32'd1);
    chk("t1_head", {24'd0, byte_out}, 32'hB2);
    chk("t1_total_bits", {16'd0, total_bits}, 32'd8);
    wait_drain("t1");
    chk("t1_pops", pop_cnt, 32'd1);

    // 2: 9-bit header then flush -> A0, 80 pad
    do_clear();
    chk("clr_total_bits", {16'd0, total_bits}, 32'd0);
    byte_ready = 1'b1;
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h80);
    send_bits(8'hA0, 8, 1'b0);
    send_bits(8'h80, 1, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_drain("t2");
    chk("t2_pops", pop_cnt, 32'd2);
    chk("t2_flush_done", fd_cnt, 32'd1);
    chk("t2_total_bits", {16'd0, total_bits}, 32'd9);

    // 3: flush on the 8th bit -> exactly one byte
    do_clear();
    byte_ready = 1'b1;
    exp_q.push_back(8'hFF);
    send_bits(8'hFF, 8, 1'b1);
    wait_drain("t3");
    chk("t3_pops", pop_cnt, 32'd1);
    chk("t3_flush_done", fd_cnt, 32'd1);

    // 4: overflow with the writer stalled
    do_clear();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    send_bits(8'h11, 8, 1'b0);
    send_bits(8'h22, 8, 1'b0);
    send_bits(8'h33, 8, 1'b0);
    send_bits(8'h44, 8, 1'b0);
    chk("t4_no_ovf_yet", {31'd0, overflow}, 32'd0);
    send_bits(8'h55, 8, 1'b0);
    chk("t4_overflow", {31'd0, overflow}, 32'd1);
    chk("t4_head_held", {24'd0, byte_out}, 32'h11);
    byte_ready = 1'b1;
    wait_drain("t4");
    chk("t4_pops", pop_cnt, 32'd4);
    chk("t4_ovf_sticky", {31'd0, overflow}, 32'd1);

    // 5: full FIFO, push coincides with pop -> no overflow
    do_clear();
    chk("clr_overflow", {31'd0, overflow}, 32'd0);
    for (int b = 1; b <= 5; b++) exp_q.push_back(8'(b));
    for (int b = 1; b <= 4; b++) send_bits(8'(b), 8, 1'b0);
    send_bits(8'h05, 7, 1'b0);
    bit_in = 1'b1; bit_valid = 1'b1; byte_ready = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0; byte_ready = 1'b0;
    chk("t5_no_overflow", {31'd0, overflow}, 32'd0);
    chk("t5_head_next", {24'd0, byte_out}, 32'h02);
    byte_ready = 1'b1;
    wait_drain("t5");
    chk("t5_pops", pop_cnt, 32'd5);

    // 6: asynchronous reset mid-byte, then clear with a bit
    do_clear();
    send_bits(8'h5A, 8, 1'b0);
    send_bits(8'hA0, 3, 1'b0);
    chk("t6_pre_valid", {31'd0, byte_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, byte_valid}, 32'd0);
    chk("t6_rst_byte_out", {24'd0, byte_out}, 32'h00);
    chk("t6_rst_total", {16'd0, total_bits}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    pop_cnt = 0;
    byte_ready = 1'b1;
    exp_q.push_back(8'hC3);
    send_bits(8'hC3, 8, 1'b0);
    wait_drain("t6a");
    chk("t6_pops", pop_cnt, 32'd1);
    chk("t6_total_bits", {16'd0, total_bits}, 32'd8);
    chk("t6_flush_done", fd_cnt, 32'd0);

    bit_in = 1'b1; bit_valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0; clear = 1'b0;
    chk("t6_clear_total", {16'd0, total_bits}, 32'd0);
    exp_q.delete();
    pop_cnt = 0;
    byte_ready = 1'b1;
    exp_q.push_back(8'h3C);
    send_bits(8'h3C, 8, 1'b0);
    wait_drain("t6b");
    chk("t6b_pops", pop_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
